spi_master_unit: RTL and testbench
==================================

# spi_master_unit

SPI mode-0 master that serialises a BITS-wide word onto MOSI while capturing a BITS-wide word from MISO, MSB first. It generates SCLK and active-low chip select from the single system clock, and sits between the host-side control logic and the SPI execution units (slaves) on the link. Transfers start with a one-cycle start request and end with a one-cycle done pulse carrying the received word.

## Interface
- BITS, default 8: frame width in bits, ≥ 1.
- CLK_DIV, default 2: SCLK half-period in i_clk cycles, ≥ 1.

- i_clk  input  1  system clock; all state updates on its rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_start  input  1  transfer request; sampled only while o_busy = 0.
- i_data  input  BITS  word to transmit; captured on the accepting edge.
- o_data  output  BITS  last received word; updated on the o_done edge, held otherwise.
- o_busy  output  1  high while a transfer is in progress.
- o_done  output  1  one-cycle pulse at end of transfer.
- o_sclk  output  1  SPI clock; idles low.
- o_mosi  output  1  serial data out.
- i_miso  input  1  serial data in.
- o_cs  output  1  chip select, active-low.

## Operation
- States: IDLE, SETUP, XFER, HOLD.
- Half-period counter counts 0..CLK_DIV-1. Each state transition or SCLK toggle happens when the counter reaches CLK_DIV-1. The counter is cleared on the start edge.
- IDLE:
  - o_cs=1, o_sclk=0, o_busy=0.
  - When i_start=1: load the TX shift register from i_data, clear the bit counter, go to SETUP.
- SETUP:
  - o_cs=0, o_mosi=TX[BITS-1], o_sclk=0.
  - After CLK_DIV cycles: o_sclk←1, capture i_miso into the LSB of the RX shift register (RX shifts left), go to XFER.
- XFER, every CLK_DIV cycles:
  - If o_sclk=1: o_sclk←0 and increment the bit counter. If this was the last bit, go to HOLD; otherwise shift TX left and present the next bit on o_mosi.
  - If o_sclk=0: o_sclk←1 and sample i_miso into RX.
- HOLD:
  - o_sclk=0, o_cs=0, o_mosi=0.
  - After CLK_DIV cycles: o_cs←1, o_busy←0, o_done←1, o_data←RX, go to IDLE.
- i_start while o_busy=1 is ignored. Changes on i_data after acceptance have no effect.
- MISO is always sampled on the i_clk edge that raises o_sclk. MOSI changes only on the edge that lowers o_sclk, or on entry to SETUP.

## Timing
- Reset values (asynchronous, applied immediately on i_rst, including mid-transfer):
  - o_cs=1, o_sclk=0, o_mosi=0, o_busy=0, o_done=0, o_data=0.
  - State is IDLE; counters and shift registers are cleared.
- Let E0 be the i_clk edge that accepts i_start. o_cs falls, o_busy rises and o_mosi=i_data[BITS-1] at E0.
- SCLK rise k (k=0..BITS-1) occurs at E0 + (2k+1)·CLK_DIV; fall k occurs at E0 + (2k+2)·CLK_DIV.
- o_done, o_cs rise and o_data update occur at E0 + (2·BITS+1)·CLK_DIV. With defaults (BITS=8, CLK_DIV=2) this is 34 cycles.
- o_done is high for exactly one cycle.
- A new i_start may be accepted in the o_done cycle (o_busy is already 0). o_cs is then high for exactly one i_clk cycle between frames.
- A start asserted in the same cycle as i_rst is discarded.
- Exactly BITS SCLK rising edges per frame; no edges occur while o_cs=1.

## Test plan
- Reset: assert i_rst mid-XFER (BITS=8, CLK_DIV=2, 5 rising edges done) → same time step: o_cs=1, o_sclk=0, o_busy=0, o_mosi=0. After release, o_done stays 0 and no SCLK edges occur.
- Loopback i_miso=o_mosi, i_data=0xA5, defaults → o_done at E0+34, o_data=0xA5. MOSI bit sequence 1,0,1,0,0,1,0,1 stable at each rising edge.
- Slave model drives 0x3C on MISO, changing on SCLK falling edges, with i_data=0x00 → o_data=0x3C, o_mosi=0 throughout.
- CLK_DIV=1, BITS=5, i_data=5'b10011, loopback → SCLK toggles every cycle, 5 rising edges, o_done at E0+11, o_data=5'b10011.
- Back-to-back: i_start held high continuously → second frame accepted on the o_done cycle. o_cs high for exactly 1 cycle between frames; o_done pulses once per frame.
- i_start pulsed and i_data changed during a transfer → ignored. Transmitted and received words are unaffected; one o_done only.

Source files
------------

// File: rtl/spi_master_unit.sv
// SPI mode-0 master: shifts a BITS-wide word out on MOSI and in from MISO, MSB first.
// SCLK half-period is CLK_DIV system clocks; one-cycle start request, one-cycle done pulse.
module spi_master_unit #(
  parameter int BITS    = 8,
  parameter int CLK_DIV = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [BITS-1:0] i_data,
  output logic [BITS-1:0] o_data,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_sclk,
  output logic            o_mosi,
  input  logic            i_miso,
  output logic            o_cs
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BITS > 1) ? $clog2(BITS + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS - 1);

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bit_cnt;
  logic [BITS-1:0] tx;
  logic [BITS-1:0] rx;
  logic [BITS-1:0] tx_shifted;
  logic [BITS-1:0] rx_shifted;
  logic            tick;

  assign tick = (cnt == CNT_LAST);

  // Shift helpers written so that BITS = 1 needs no special case.
  always_comb begin
    tx_shifted    = tx << 1;
    rx_shifted    = rx << 1;
    rx_shifted[0] = i_miso;
  end

  // NOTE: every register here uses <= so all of them see pre-edge values of each
  // other; blocking assignments would make the result depend on statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      tx      <= '0;
      rx      <= '0;
      o_data  <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_sclk  <= 1'b0;
      o_mosi  <= 1'b0;
      o_cs    <= 1'b1;
    end else begin
      // NOTE: o_done defaults low each cycle so the single set below is a one-cycle pulse.
      o_done <= 1'b0;

      if (state == S_IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= tick ? '0 : cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (i_start) begin
            tx      <= i_data;
            rx      <= '0;
            bit_cnt <= '0;
            o_cs    <= 1'b0;
            o_busy  <= 1'b1;
            o_mosi  <= i_data[BITS-1];
            state   <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (tick) begin
            o_sclk <= 1'b1;
            rx     <= rx_shifted;
            state  <= S_XFER;
          end
        end

        S_XFER: begin
          if (tick) begin
            if (o_sclk) begin
              o_sclk  <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
                o_mosi <= 1'b0;
                state  <= S_HOLD;
              end else begin
                tx     <= tx_shifted;
                o_mosi <= tx_shifted[BITS-1];
              end
            end else begin
              o_sclk <= 1'b1;
              rx     <= rx_shifted;
            end
          end
        end

        S_HOLD: begin
          if (tick) begin
            o_cs   <= 1'b1;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            o_data <= rx;
            state  <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_unit.sv
// Bench for spi_master_unit: a default instance (BITS=8, CLK_DIV=2) and a fast one
// (BITS=5, CLK_DIV=1), each with a scoreboard of expected transmit/receive words.
module tb_spi_master_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: default parameters.
  logic       start_a, busy_a, done_a, sclk_a, mosi_a, miso_a, cs_a;
  logic [7:0] data_a, odata_a;
  logic       loop_a = 1'b1;
  logic [7:0] slave_word = 8'h00;
  int         sl_cnt = 0;

  // Instance B: five-bit frames, SCLK toggling every system clock.
  logic       start_b, busy_b, done_b, sclk_b, mosi_b, miso_b, cs_b;
  logic [4:0] data_b, odata_b;

  spi_master_unit dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_data(data_a), .o_data(odata_a),
    .o_busy(busy_a), .o_done(done_a), .o_sclk(sclk_a), .o_mosi(mosi_a),
    .i_miso(miso_a), .o_cs(cs_a)
  );

  spi_master_unit #(.BITS(5), .CLK_DIV(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_data(data_b), .o_data(odata_b),
    .o_busy(busy_b), .o_done(done_b), .o_sclk(sclk_b), .o_mosi(mosi_b),
    .i_miso(miso_b), .o_cs(cs_b)
  );

  // Slave model: presents slave_word MSB first, advancing on each SCLK fall.
  always @(negedge sclk_a or posedge cs_a) begin
    if (cs_a) sl_cnt = 0;
    else      sl_cnt = sl_cnt + 1;
  end

  assign miso_a = loop_a ? mosi_a : ((sl_cnt < 8) ? slave_word[7 - sl_cnt] : 1'b0);
  assign miso_b = mosi_b;

  typedef struct { logic [7:0] tx; logic [7:0] rx; } exp_a_t;
  typedef struct { logic [4:0] tx; logic [4:0] rx; } exp_b_t;
  exp_a_t q_a[$];
  exp_b_t q_b[$];

  int         rises_a = 0, rises_b = 0, dones_a = 0, dones_b = 0;
  logic [7:0] word_a = '0;
  logic [4:0] word_b = '0;
  logic       prev_sclk_a = 1'b0, prev_sclk_b = 1'b0;

  // Monitor/scoreboard for A: MOSI captured at each SCLK rise, compared on o_done.
  always @(negedge clk) begin
    exp_a_t e;
    if (rst) begin
      rises_a = 0; word_a = '0; prev_sclk_a = 1'b0;
    end else begin
      checks++;
      if (cs_a === 1'b1 && sclk_a !== 1'b0) begin
        errors++;
        $display("FAIL a_sclk_idle: sclk %b while cs high, want 0", sclk_a);
      end
      if (sclk_a === 1'b1 && prev_sclk_a === 1'b0) begin
        word_a = {word_a[6:0], mosi_a};
        rises_a++;
      end
      prev_sclk_a = sclk_a;
      if (done_a === 1'b1) begin
        dones_a++;
        checks++;
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL a_unexpected_done: got done with data %h, want no done", odata_a);
        end else begin
          e = q_a.pop_front();
          if (odata_a !== e.rx) begin
            errors++; $display("FAIL a_rx_word: got %h want %h", odata_a, e.rx);
          end
          checks++;
          if (word_a !== e.tx) begin
            errors++; $display("FAIL a_mosi_word: got %h want %h", word_a, e.tx);
          end
          checks++;
          if (rises_a != 8) begin
            errors++; $display("FAIL a_rise_count: got %0d want 8", rises_a);
          end
        end
        rises_a = 0; word_a = '0;
      end
    end
  end

  // Monitor/scoreboard for B.
  always @(negedge clk) begin
    exp_b_t e;
    if (rst) begin
      rises_b = 0; word_b = '0; prev_sclk_b = 1'b0;
    end else begin
      checks++;
      if (cs_b === 1'b1 && sclk_b !== 1'b0) begin
        errors++;
        $display("FAIL b_sclk_idle: sclk %b while cs high, want 0", sclk_b);
      end
      if (sclk_b === 1'b1 && prev_sclk_b === 1'b0) begin
        word_b = {word_b[3:0], mosi_b};
        rises_b++;
      end
      prev_sclk_b = sclk_b;
      if (done_b === 1'b1) begin
        dones_b++;
        checks++;
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected_done: got done with data %h, want no done", odata_b);
        end else begin
          e = q_b.pop_front();
          if (odata_b !== e.rx) begin
            errors++; $display("FAIL b_rx_word: got %b want %b", odata_b, e.rx);
          end
          checks++;
          if (word_b !== e.tx) begin
            errors++; $display("FAIL b_mosi_word: got %b want %b", word_b, e.tx);
          end
          checks++;
          if (rises_b != 5) begin
            errors++; $display("FAIL b_rise_count: got %0d want 5", rises_b);
          end
        end
        rises_b = 0; word_b = '0;
      end
    end
  end

  // Pulse start on A and return the cycle number of the accepting edge.
  task automatic start_frame_a(input logic [7:0] d, output int e0);
    @(posedge clk); #1;
    data_a  = d;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    e0 = cyc;
    checks++;
    if ({cs_a, busy_a, mosi_a} !== {1'b0, 1'b1, d[7]}) begin
      errors++;
      $display("FAIL a_accept: cs/busy/mosi got %b want %b", {cs_a, busy_a, mosi_a}, {1'b0, 1'b1, d[7]});
    end
  endtask

  // Wait (bounded) for A's done pulse; returns its cycle number, or -1 on timeout.
  task automatic wait_done_a(input string name, output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done within 200 cycles, want done", name);
    end
  endtask

  task automatic test_reset;
    int n;
    logic prev, bad;
    #1;
    checks++;
    if ({cs_a, sclk_a, mosi_a, busy_a, done_a, odata_a} !== {5'b10000, 8'h00}) begin
      errors++;
      $display("FAIL reset_values_a: got %b want %b", {cs_a, sclk_a, mosi_a, busy_a, done_a, odata_a}, {5'b10000, 8'h00});
    end
    checks++;
    if ({cs_b, sclk_b, mosi_b, busy_b, done_b, odata_b} !== {5'b10000, 5'b00000}) begin
      errors++;
      $display("FAIL reset_values_b: got %b want %b", {cs_b, sclk_b, mosi_b, busy_b, done_b, odata_b}, {5'b10000, 5'b00000});
    end

    // Start presented together with reset must be dropped.
    @(posedge clk); #1;
    data_a  = 8'hFF;
    start_a = 1'b1;
    @(posedge clk); #1;
    rst     = 1'b0;
    start_a = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_a, cs_a} !== 2'b01) begin
      errors++; $display("FAIL reset_start_drop: busy/cs got %b want 01", {busy_a, cs_a});
    end

    // Reset mid-XFER after five SCLK rises.
    loop_a = 1'b1;
    q_a.push_back('{tx: 8'hA5, rx: 8'hA5});
    start_frame_a(8'hA5, n);
    n = 0;
    prev = 1'b0;
    for (int i = 0; i < 100 && n < 5; i++) begin
      @(negedge clk);
      if (sclk_a && !prev) n++;
      prev = sclk_a;
    end
    checks++;
    if (n != 5) begin
      errors++; $display("FAIL reset_mid_reach: got %0d rises want 5", n);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cs_a, sclk_a, busy_a, mosi_a} !== 4'b1000) begin
      errors++; $display("FAIL reset_mid_xfer: cs/sclk/busy/mosi got %b want 1000", {cs_a, sclk_a, busy_a, mosi_a});
    end
    q_a.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_a !== 1'b0 || sclk_a !== 1'b0 || busy_a !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL reset_quiet: got activity after reset release, want none");
    end
  endtask

  task automatic test_loopback;
    int e0, t;
    loop_a = 1'b1;
    q_a.push_back('{tx: 8'hA5, rx: 8'hA5});
    start_frame_a(8'hA5, e0);
    wait_done_a("loopback", t);
    checks++;
    if (t - e0 != 34) begin
      errors++; $display("FAIL loopback_latency: got %0d want 34", t - e0);
    end
    checks++;
    if ({cs_a, busy_a, odata_a} !== {2'b10, 8'hA5}) begin
      errors++; $display("FAIL loopback_end: cs/busy/data got %b want %b", {cs_a, busy_a, odata_a}, {2'b10, 8'hA5});
    end
  endtask

  task automatic test_slave;
    int   e0, t;
    logic mosi_seen;
    loop_a     = 1'b0;
    slave_word = 8'h3C;
    q_a.push_back('{tx: 8'h00, rx: 8'h3C});
    start_frame_a(8'h00, e0);
    mosi_seen = 1'b0;
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mosi_a !== 1'b0) mosi_seen = 1'b1;
      if (done_a === 1'b1) begin
        t = cyc;
        break;
      end
    end
    checks++;
    if (t - e0 != 34) begin
      errors++; $display("FAIL slave_latency: got %0d want 34", t - e0);
    end
    checks++;
    if (mosi_seen) begin
      errors++; $display("FAIL slave_mosi_zero: got mosi 1 during frame want 0");
    end
    loop_a = 1'b1;
  endtask

  task automatic test_div1;
    int   e0, t, toggles;
    logic prev;
    q_b.push_back('{tx: 5'b10011, rx: 5'b10011});
    @(posedge clk); #1;
    data_b  = 5'b10011;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    data_b  = 5'b01100;
    e0 = cyc;
    prev = sclk_b;
    toggles = 0;
    t = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sclk_b !== prev) toggles++;
      prev = sclk_b;
      if (done_b === 1'b1) begin
        t = cyc;
        break;
      end
    end
    checks++;
    if (t - e0 != 11) begin
      errors++; $display("FAIL div1_latency: got %0d want 11", t - e0);
    end
    checks++;
    if (toggles != 10) begin
      errors++; $display("FAIL div1_toggles: got %0d want 10", toggles);
    end
  endtask

  task automatic test_back_to_back;
    int e0, t1, t2, d0;
    loop_a = 1'b1;
    @(posedge clk); #1;
    d0 = dones_a;
    q_a.push_back('{tx: 8'h5A, rx: 8'h5A});
    q_a.push_back('{tx: 8'hC3, rx: 8'hC3});
    data_a  = 8'h5A;
    start_a = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    data_a = 8'hC3;
    wait_done_a("b2b_first", t1);
    checks++;
    if ({cs_a, busy_a} !== 2'b10) begin
      errors++; $display("FAIL b2b_gap_high: cs/busy got %b want 10", {cs_a, busy_a});
    end
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if ({cs_a, busy_a, done_a} !== 3'b010) begin
      errors++; $display("FAIL b2b_gap_one_cycle: cs/busy/done got %b want 010", {cs_a, busy_a, done_a});
    end
    wait_done_a("b2b_second", t2);
    checks++;
    if (t1 - e0 != 34 || t2 - t1 != 35) begin
      errors++; $display("FAIL b2b_latency: got %0d/%0d want 34/35", t1 - e0, t2 - t1);
    end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (dones_a - d0 != 2 || busy_a !== 1'b0) begin
      errors++; $display("FAIL b2b_done_count: got %0d busy %b want 2 busy 0", dones_a - d0, busy_a);
    end
  endtask

  task automatic test_ignore;
    int e0, t, d0;
    loop_a = 1'b1;
    @(posedge clk); #1;
    d0 = dones_a;
    q_a.push_back('{tx: 8'h96, rx: 8'h96});
    start_frame_a(8'h96, e0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      start_a = i[0];
      data_a  = 8'hFF ^ 8'(i);
    end
    start_a = 1'b0;
    wait_done_a("ignore", t);
    checks++;
    if (t - e0 != 34) begin
      errors++; $display("FAIL ignore_latency: got %0d want 34", t - e0);
    end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (dones_a - d0 != 1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL ignore_done_count: got %0d busy %b want 1 busy 0", dones_a - d0, busy_a);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    data_a  = '0;
    data_b  = '0;
    test_reset();
    test_loopback();
    test_slave();
    test_div1();
    test_back_to_back();
    test_ignore();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d/%0d pending want 0/0", q_a.size(), q_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
